fe_fifo_decoder: RTL and testbench

Read-side decoder for the front-end capture FIFO. It pops entries (command, time, data, status) from a first-word-fall-through FIFO and turns relative short and long timestamps into an absolute timestamp. It tracks USB packet framing from the RXACTIVE status bit and emits one decoded event per DATA/STAT entry on a valid/ready stream. It sits between the capture FIFO and the on-board trigger/analysis logic, or a host streaming engine.

---
 rtl/fe_fifo_decoder.sv | 115 +++++++++++
 tb/tb_fe_fifo_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fe_fifo_decoder.sv
// fe_fifo_decoder: pops a FWFT capture FIFO, rebuilds absolute time and USB packet framing, emits DATA/STAT events
// Ports:
//   fe_clk, reset_i, I_clear          clock, sync active-high reset, sync soft clear
//   I_fifo_*                           FWFT FIFO head entry (empty, command, time, data, status)
//   O_fifo_rd                          pop strobe (combinational)
//   O_ev_* / I_ev_ready                decoded event stream (valid/ready)
//   O_pkt_count, O_time_sat            completed packets, sticky accumulator saturation
// Command encoding: 0 DATA, 1 STAT, 2 TIME, 3 invalid. RXACTIVE is status bit 0.
module fe_fifo_decoder #(
  parameter int pTIMESTAMP_FULL_WIDTH = 16,
  parameter int pABS_TIME_WIDTH = 32,
  parameter int pIDX_WIDTH = 11,
  parameter int pPKT_CNT_WIDTH = 16
) (
  input  logic fe_clk,
  input  logic reset_i,
  input  logic I_clear,
  input  logic I_fifo_empty,
  input  logic [1:0] I_fifo_command,
  input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_fifo_time,
  input  logic [7:0] I_fifo_data,
  input  logic [4:0] I_fifo_status,
  output logic O_fifo_rd,
  output logic O_ev_valid,
  input  logic I_ev_ready,
  output logic [pABS_TIME_WIDTH-1:0] O_ev_time,
  output logic [7:0] O_ev_data,
  output logic [4:0] O_ev_status,
  output logic O_ev_is_data,
  output logic O_ev_pkt_start,
  output logic O_ev_pkt_end,
  output logic O_ev_orphan,
  output logic [pIDX_WIDTH-1:0] O_ev_index,
  output logic [pPKT_CNT_WIDTH-1:0] O_pkt_count,
  output logic O_time_sat
);
  localparam logic [1:0] pCMD_DATA = 2'd0;
  localparam logic [1:0] pCMD_STAT = 2'd1;
  localparam logic [1:0] pCMD_TIME = 2'd2;
  localparam int pRX_BIT = 0;
  typedef enum logic {pS_NOPKT, pS_INPKT} state_t;
  state_t state, state_n;
  logic [pABS_TIME_WIDTH-1:0] acc, acc_n;
  logic [pABS_TIME_WIDTH:0] sum;
  logic [pIDX_WIDTH-1:0] idx, idx_n;
  logic [pPKT_CNT_WIDTH-1:0] cnt_n;
  logic sat_n, last_rx, last_rx_n, is_data, is_stat, is_time, rx, in_pkt, rise, fall, load;
  assign O_fifo_rd = !reset_i && !I_clear && !I_fifo_empty && (!O_ev_valid || I_ev_ready);
  always_comb begin
    is_data = I_fifo_command == pCMD_DATA;
    is_stat = I_fifo_command == pCMD_STAT;
    is_time = I_fifo_command == pCMD_TIME;
    rx = I_fifo_status[pRX_BIT];
    in_pkt = state == pS_INPKT;
    rise = is_stat && !in_pkt && !last_rx && rx;
    fall = is_stat && in_pkt && last_rx && !rx;
    load = O_fifo_rd && (is_data || is_stat);
    // one extra carry bit detects overflow; the result clamps to all-ones
    sum = {1'b0, acc} + (pABS_TIME_WIDTH+1)'(I_fifo_time);
    acc_n = acc;
    sat_n = O_time_sat;
    state_n = state;
    last_rx_n = last_rx;
    idx_n = idx;
    cnt_n = O_pkt_count;
    if (O_fifo_rd && (is_data || is_stat || is_time)) begin
      acc_n = sum[pABS_TIME_WIDTH] ? '1 : sum[pABS_TIME_WIDTH-1:0];
      sat_n = O_time_sat | sum[pABS_TIME_WIDTH];
    end
    if (O_fifo_rd && is_stat) begin
      last_rx_n = rx;
      state_n = rise ? pS_INPKT : fall ? pS_NOPKT : state;
      idx_n = rise ? '0 : idx;
      cnt_n = fall ? O_pkt_count + 1'b1 : O_pkt_count;
    end
    if (O_fifo_rd && is_data && in_pkt) idx_n = &idx ? idx : idx + 1'b1;
  end
  always_ff @(posedge fe_clk) begin
    if (reset_i || I_clear) begin
      state <= pS_NOPKT;
      acc <= '0;
      last_rx <= 1'b0;
      idx <= '0;
      O_pkt_count <= '0;
      O_time_sat <= 1'b0;
      O_ev_valid <= 1'b0;
      O_ev_time <= '0;
      O_ev_data <= '0;
      O_ev_status <= '0;
      O_ev_is_data <= 1'b0;
      O_ev_pkt_start <= 1'b0;
      O_ev_pkt_end <= 1'b0;
      O_ev_orphan <= 1'b0;
      O_ev_index <= '0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      last_rx <= last_rx_n;
      idx <= idx_n;
      O_pkt_count <= cnt_n;
      O_time_sat <= sat_n;
      if (load) begin
        O_ev_valid <= 1'b1;
        O_ev_time <= acc_n;
        O_ev_data <= is_data ? I_fifo_data : 8'd0;
        O_ev_status <= I_fifo_status;
        O_ev_is_data <= is_data;
        O_ev_pkt_start <= rise;
        O_ev_pkt_end <= fall;
        O_ev_orphan <= is_data && !in_pkt;
        O_ev_index <= (is_data && in_pkt) ? idx : '0;
      end else if (I_ev_ready) O_ev_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fe_fifo_decoder.sv
// tb_fe_fifo_decoder: FIFO model feeding fe_fifo_decoder, checked against a time/framing reference model
module tb_fe_fifo_decoder;
  localparam int TW = 24;
  localparam int IW = 4;
  localparam int CW = 4;
  localparam longint MAX = 64'hFFFF_FFFF;
  localparam logic [1:0] C_DATA = 2'd0, C_STAT = 2'd1, C_TIME = 2'd2, C_BAD = 2'd3;
  typedef struct packed {logic [1:0] c; logic [TW-1:0] t; logic [7:0] d; logic [4:0] s;} ent_t;
  typedef struct {logic [31:0] t; logic [7:0] d; logic [IW-1:0] i; logic st, en, orph;} ev_t;
  logic fe_clk = 0, reset_i, I_clear, I_fifo_empty, I_ev_ready;
  logic [1:0] I_fifo_command;
  logic [TW-1:0] I_fifo_time;
  logic [7:0] I_fifo_data;
  logic [4:0] I_fifo_status;
  logic O_fifo_rd, O_ev_valid, O_ev_is_data, O_ev_pkt_start, O_ev_pkt_end, O_ev_orphan, O_time_sat;
  logic [31:0] O_ev_time;
  logic [7:0] O_ev_data;
  logic [4:0] O_ev_status;
  logic [IW-1:0] O_ev_index;
  logic [CW-1:0] O_pkt_count;
  logic [58:0] outs;
  ent_t q[$];
  ev_t lg[$];
  int n_chk = 0, n_fail = 0;
  longint m_acc;
  bit m_sat, m_rx, m_valid, m_isd, m_start, m_end, m_orph;
  int m_idx, m_cnt, m_index;
  logic [31:0] m_time;
  logic [7:0] m_data;
  logic [4:0] m_st;
  bit gen_rx;
  fe_fifo_decoder #(.pTIMESTAMP_FULL_WIDTH(TW), .pABS_TIME_WIDTH(32), .pIDX_WIDTH(IW), .pPKT_CNT_WIDTH(CW)) dut (
    .fe_clk(fe_clk), .reset_i(reset_i), .I_clear(I_clear), .I_fifo_empty(I_fifo_empty),
    .I_fifo_command(I_fifo_command), .I_fifo_time(I_fifo_time), .I_fifo_data(I_fifo_data),
    .I_fifo_status(I_fifo_status), .O_fifo_rd(O_fifo_rd), .O_ev_valid(O_ev_valid), .I_ev_ready(I_ev_ready),
    .O_ev_time(O_ev_time), .O_ev_data(O_ev_data), .O_ev_status(O_ev_status), .O_ev_is_data(O_ev_is_data),
    .O_ev_pkt_start(O_ev_pkt_start), .O_ev_pkt_end(O_ev_pkt_end), .O_ev_orphan(O_ev_orphan),
    .O_ev_index(O_ev_index), .O_pkt_count(O_pkt_count), .O_time_sat(O_time_sat));
  assign outs = {O_ev_valid, O_ev_time, O_ev_data, O_ev_status, O_ev_is_data, O_ev_pkt_start,
                 O_ev_pkt_end, O_ev_orphan, O_ev_index, O_pkt_count, O_time_sat};
  always #5 fe_clk = ~fe_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void push(input logic [1:0] c, input logic [TW-1:0] t, input logic [7:0] d, input logic [4:0] s);
    q.push_back(ent_t'({c, t, d, s}));
  endfunction
  function automatic void model_clear();
    m_acc = 0; m_sat = 0; m_rx = 0; m_valid = 0; m_idx = 0; m_cnt = 0;
  endfunction
  function automatic void apply(input ent_t e, input bit rdy);
    longint s;
    if (e.c != C_BAD) begin
      s = m_acc + longint'(e.t);
      if (s > MAX) begin s = MAX; m_sat = 1; end
      m_acc = s;
    end
    if (e.c == C_DATA || e.c == C_STAT) begin
      m_valid = 1; m_time = m_acc[31:0]; m_st = e.s; m_isd = e.c == C_DATA;
      m_data = m_isd ? e.d : 8'd0;
      m_start = 0; m_end = 0; m_orph = 0; m_index = 0;
      if (m_isd) begin
        if (m_rx) begin
          m_index = m_idx;
          m_idx = (m_idx == (1 << IW) - 1) ? m_idx : m_idx + 1;
        end else m_orph = 1;
      end else begin
        m_start = e.s[0] && !m_rx;
        m_end = !e.s[0] && m_rx;
        if (m_start) m_idx = 0;
        if (m_end) m_cnt = (m_cnt + 1) % (1 << CW);
        m_rx = e.s[0];
      end
    end else if (rdy) m_valid = 0;
  endfunction
  task automatic step(input bit rdy, input bit clr);
    bit exp_rd;
    ent_t e;
    @(negedge fe_clk);
    I_ev_ready = rdy; I_clear = clr;
    if (q.size() != 0) begin
      I_fifo_empty = 0;
      {I_fifo_command, I_fifo_time, I_fifo_data, I_fifo_status} = q[0];
    end else begin
      I_fifo_empty = 1;
      {I_fifo_command, I_fifo_time, I_fifo_data, I_fifo_status} = TW'($urandom) << 15 | 15'($urandom);
    end
    #1;
    exp_rd = !clr && q.size() != 0 && (!m_valid || rdy);
    chk("fifo_rd", O_fifo_rd, exp_rd);
    if (!clr && O_ev_valid && rdy)
      lg.push_back('{O_ev_time, O_ev_data, O_ev_index, O_ev_pkt_start, O_ev_pkt_end, O_ev_orphan});
    if (clr) model_clear();
    else if (exp_rd) begin e = q.pop_front(); apply(e, rdy); end
    else if (rdy) m_valid = 0;
    @(posedge fe_clk); #1;
    chk("valid", O_ev_valid, m_valid);
    chk("pkt_count", O_pkt_count, m_cnt);
    chk("time_sat", O_time_sat, m_sat);
    if (m_valid) begin
      chk("ev_time", O_ev_time, m_time);
      chk("ev_data", O_ev_data, m_data);
      chk("ev_status", O_ev_status, m_st);
      chk("ev_is_data", O_ev_is_data, m_isd);
      chk("ev_start", O_ev_pkt_start, m_start);
      chk("ev_end", O_ev_pkt_end, m_end);
      chk("ev_orphan", O_ev_orphan, m_orph);
      chk("ev_index", O_ev_index, m_index);
    end
  endtask
  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || m_valid) && k < 2000) begin step(1, 0); k++; end
    chk("drain_budget", k < 2000, 1);
  endtask
  task automatic seq1();
    push(C_TIME, 24'hFFFE, 8'h00, 5'b00000);
    push(C_STAT, 24'd5, 8'h00, 5'b00001);
    push(C_DATA, 24'd0, 8'h2D, 5'b00001);
    push(C_DATA, 24'd2, 8'hA5, 5'b00001);
    push(C_STAT, 24'd1, 8'h00, 5'b00000);
  endtask
  task automatic check_seq1(input string p);
    chk({p, "_n"}, lg.size(), 4);
    if (lg.size() >= 4) begin
      chk({p, "_t0"}, lg[0].t, 32'h10003); chk({p, "_start"}, lg[0].st, 1);
      chk({p, "_t1"}, lg[1].t, 32'h10003); chk({p, "_d1"}, lg[1].d, 8'h2D); chk({p, "_i1"}, lg[1].i, 0);
      chk({p, "_t2"}, lg[2].t, 32'h10005); chk({p, "_d2"}, lg[2].d, 8'hA5); chk({p, "_i2"}, lg[2].i, 1);
      chk({p, "_t3"}, lg[3].t, 32'h10006); chk({p, "_end"}, lg[3].en, 1);
    end
    chk({p, "_cnt"}, O_pkt_count, 1);
  endtask
  initial begin
    int k;
    reset_i = 1; I_clear = 0; I_ev_ready = 1;
    model_clear();
    push(C_DATA, 24'd4, 8'h55, 5'b00001);
    {I_fifo_command, I_fifo_time, I_fifo_data, I_fifo_status} = q[0];
    I_fifo_empty = 0;
    repeat (3) begin @(negedge fe_clk); #1; chk("rst_rd", O_fifo_rd, 0); end
    chk("rst_out", outs, 0);
    q.delete(); I_fifo_empty = 1; reset_i = 0;
    seq1(); drain(); check_seq1("seq");
    step(1, 1); lg.delete();
    seq1();
    k = 0;
    while (!O_ev_valid && k < 10) begin step(0, 0); k++; end
    chk("hold_wait", O_ev_valid, 1);
    repeat (5) begin
      step(0, 0);
      chk("hold_rd", O_fifo_rd, 0);
      chk("hold_t", O_ev_time, 32'h10003);
    end
    drain(); check_seq1("hold");
    step(1, 1); lg.delete();
    push(C_DATA, 24'd3, 8'h11, 5'b00000); drain();
    chk("orph_n", lg.size(), 1);
    if (lg.size() == 1) begin
      chk("orph_flag", lg[0].orph, 1); chk("orph_idx", lg[0].i, 0); chk("orph_t", lg[0].t, 3);
    end
    chk("orph_cnt", O_pkt_count, 0);
    step(1, 1); lg.delete();
    repeat (256) push(C_TIME, 24'hFFFFFF, 8'h00, 5'b00000);
    push(C_TIME, 24'hF0, 8'h00, 5'b00000);
    push(C_DATA, 24'h20, 8'h77, 5'b00000);
    push(C_STAT, 24'd1, 8'h00, 5'b00010);
    drain();
    chk("sat_n", lg.size(), 2);
    if (lg.size() == 2) chk("sat_t", lg[0].t, 32'hFFFFFFFF);
    chk("sat_sticky", O_time_sat, 1);
    step(1, 1);
    chk("sat_clr", O_time_sat, 0);
    lg.delete();
    push(C_DATA, 24'd7, 8'h01, 5'b00000);
    push(C_DATA, 24'd4, 8'h02, 5'b00000);
    step(0, 0); step(0, 0);
    chk("clr_pend", O_ev_valid, 1);
    step(0, 1);
    chk("clr_out", outs, 0);
    drain();
    chk("clr_n", lg.size(), 1);
    if (lg.size() == 1) chk("clr_t4", lg[0].t, 4);
    step(1, 1); lg.delete();
    push(C_DATA, 24'd1, 8'h0A, 5'b00000);
    push(C_BAD, 24'd9, 8'h0B, 5'b00000);
    push(C_DATA, 24'd1, 8'h0C, 5'b00000);
    drain();
    chk("bad_n", lg.size(), 2);
    if (lg.size() == 2) begin chk("bad_t0", lg[0].t, 1); chk("bad_t1", lg[1].t, 2); end
    step(1, 1); lg.delete();
    push(C_STAT, 24'd0, 8'h00, 5'b00001);
    repeat (18) push(C_DATA, 24'd0, 8'h33, 5'b00001);
    push(C_STAT, 24'd0, 8'h00, 5'b00000);
    drain();
    chk("isat_n", lg.size(), 20);
    if (lg.size() == 20) begin
      chk("isat_i14", lg[15].i, 14); chk("isat_i15", lg[16].i, 15); chk("isat_hold", lg[18].i, 15);
    end
    step(1, 1); gen_rx = 0; k = 0;
    for (int c = 0; c < 1500; c++) begin
      if (k < 600 && $urandom_range(0, 9) < 6) begin
        int r;
        logic [TW-1:0] t;
        logic [4:0] s;
        r = $urandom_range(0, 9);
        t = ($urandom_range(0, 19) == 0) ? TW'($urandom) : TW'($urandom_range(0, 3));
        s = 5'($urandom);
        if (r >= 4 && r <= 6 && $urandom_range(0, 2) == 0) gen_rx = !gen_rx;
        s[0] = gen_rx;
        push(r < 4 ? C_DATA : r < 7 ? C_STAT : r < 9 ? C_TIME : C_BAD, t, 8'($urandom), s);
        k++;
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
    end
    drain();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
